// File: rtl/clock_set_controller.sv
// Sequencer for the clock-calendar counters: cascades the 1 Hz tick in RUN and
// routes debounced key presses to a single field while a SET mode pauses time.
module clock_set_controller #(
    parameter logic [7:0]  SEC_LAST  = 8'h59,
    parameter logic [7:0]  MIN_LAST  = 8'h59,
    parameter logic [7:0]  HOUR_LAST = 8'h23,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       CP,
    input  logic       RSTn,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [7:0] sec_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] hour_bcd,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       day_en,
    output logic [1:0] mode,
    output logic       field_blank
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } mode_e;

    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_S);
    localparam bit         TIMEOUT_ON = (TIMEOUT_S != 0);

    mode_e      mode_q;
    logic [7:0] idle_q;
    logic       blank_q;
    logic       sec_en_q;
    logic       min_en_q;
    logic       hour_en_q;
    logic       day_en_q;

    always_ff @(posedge CP or negedge RSTn) begin
        if (!RSTn) begin
            mode_q    <= RUN;
            idle_q    <= 8'd0;
            blank_q   <= 1'b0;
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            hour_en_q <= 1'b0;
            day_en_q  <= 1'b0;
        end else begin
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            hour_en_q <= 1'b0;
            day_en_q  <= 1'b0;

            if (mode_q == RUN) begin
                idle_q  <= 8'd0;
                blank_q <= 1'b0;
                if (tick_1hz) begin
                    sec_en_q <= 1'b1;
                    if (sec_bcd == SEC_LAST) begin
                        min_en_q <= 1'b1;
                        if (min_bcd == MIN_LAST) begin
                            hour_en_q <= 1'b1;
                            if (hour_bcd == HOUR_LAST) begin
                                day_en_q <= 1'b1;
                            end
                        end
                    end
                end
                if (key_mode) begin
                    mode_q <= SET_HOUR;
                end
            // A matured idle count returns to RUN ahead of any key seen that cycle.
            end else if (TIMEOUT_ON && idle_q == TIMEOUT_V) begin
                mode_q  <= RUN;
                idle_q  <= 8'd0;
                blank_q <= 1'b0;
            end else if (key_mode) begin
                mode_q  <= mode_e'(mode_q + 2'd1);
                idle_q  <= 8'd0;
                blank_q <= 1'b0;
            end else if (key_inc) begin
                idle_q  <= 8'd0;
                blank_q <= 1'b0;
                case (mode_q)
                    SET_HOUR: hour_en_q <= 1'b1;
                    SET_MIN:  min_en_q  <= 1'b1;
                    default:  sec_en_q  <= 1'b1;
                endcase
            end else if (tick_1hz) begin
                blank_q <= ~blank_q;
                if (idle_q != 8'hFF) begin
                    idle_q <= idle_q + 8'd1;
                end
            end
        end
    end

    assign sec_en      = sec_en_q;
    assign min_en      = min_en_q;
    assign hour_en     = hour_en_q;
    assign day_en      = day_en_q;
    assign mode        = mode_q;
    assign field_blank = blank_q;

endmodule
